// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher for a 1x4 demux: one held word, steered by sel, with an optional stall timeout.
// Define DEMUX_SCHED_CNT_EN to add per-channel saturating dispatch counters exported on cnt_flat.
module demux_rr_dispatcher #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       sel,
  output logic             timeout
`ifdef DEMUX_SCHED_CNT_EN
  ,
  output logic [4*CNT_W-1:0] cnt_flat
`endif
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state;
  logic          valid;  // low in FULL only during the one-cycle bubble after a timeout
  logic [1:0]    ptr;
  logic [TW-1:0] timer;
  logic          hs;

  assign hs        = (state == FULL) && valid && out_ready[sel];
  // Gating with the handshake (not bare out_ready) keeps a word from being overwritten during the bubble.
  assign in_ready  = (state == EMPTY) || hs;
  assign out_valid = valid ? (4'b0001 << sel) : 4'b0000;

  // NOTE: all state here is sequential, so every assignment uses <= to avoid ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      valid    <= 1'b0;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      timer    <= '0;
      timeout  <= 1'b0;
      out_data <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        EMPTY: begin
          if (in_valid) begin
            out_data <= in_data;
            sel      <= ptr;
            timer    <= '0;
            valid    <= 1'b1;
            state    <= FULL;
          end
        end
        FULL: begin
          if (hs) begin
            ptr <= sel + 2'd1;
            if (in_valid) begin
              out_data <= in_data;
              sel      <= sel + 2'd1;
              timer    <= '0;
            end else begin
              valid <= 1'b0;
              state <= EMPTY;
            end
          end else if (!valid) begin
            valid <= 1'b1;
          end else if (TIMEOUT > 0 && timer == T_LAST) begin
            sel     <= sel + 2'd1;
            timer   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b1;
          end else if (timer != {TW{1'b1}}) begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef DEMUX_SCHED_CNT_EN
  logic [CNT_W-1:0] cnt [4];

  // NOTE: the counter array is small register state, so it is reset explicitly like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (hs && cnt[sel] != {CNT_W{1'b1}}) begin
      cnt[sel] <= cnt[sel] + 1'b1;
    end
  end

  assign cnt_flat = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: a TIMEOUT=0 and a TIMEOUT=4 instance share stimulus and are
// each compared every cycle against a transaction-level reference model.
module tb_demux_rr_dispatcher;

  localparam int CW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] out_ready = '0;

  logic       ir0, ir4, to0, to4;
  logic [3:0] ov0, ov4;
  logic [7:0] od0, od4;
  logic [1:0] sl0, sl4;
`ifdef DEMUX_SCHED_CNT_EN
  logic [4*CW-1:0] cf0, cf4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.WIDTH(8), .TIMEOUT(0), .CNT_W(CW)) u_t0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .sel(sl0), .timeout(to0)
`ifdef DEMUX_SCHED_CNT_EN
    , .cnt_flat(cf0)
`endif
  );

  demux_rr_dispatcher #(.WIDTH(8), .TIMEOUT(4), .CNT_W(CW)) u_t4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .sel(sl4), .timeout(to4)
`ifdef DEMUX_SCHED_CNT_EN
    , .cnt_flat(cf4)
`endif
  );

  // Reference model: a held word, its target channel, how long it has waited, rotation pointer.
  int         tmo_cfg [2] = '{0, 4};
  bit         m_full [2];
  bit         m_bub  [2];
  bit         m_tmo  [2];
  logic [7:0] m_data [2];
  int         m_sel  [2];
  int         m_ptr  [2];
  int         m_age  [2];
  int         m_cnt  [2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 0; m_bub[d] = 0; m_tmo[d] = 0; m_data[d] = '0;
      m_sel[d] = 0; m_ptr[d] = 0; m_age[d] = 0;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
    end
  endtask

  function automatic logic [3:0] exp_valid(input int d);
    return (m_full[d] && !m_bub[d]) ? (4'b0001 << m_sel[d]) : 4'b0000;
  endfunction

  task automatic model_step(input int d, input logic iv, input logic [7:0] id, input logic [3:0] ordy);
    m_tmo[d] = 0;
    if (!m_full[d]) begin
      if (iv) begin
        m_full[d] = 1; m_data[d] = id; m_sel[d] = m_ptr[d]; m_age[d] = 0;
      end
    end else if (m_bub[d]) begin
      m_bub[d] = 0;
    end else if (ordy[m_sel[d]]) begin
      if (m_cnt[d][m_sel[d]] < (1 << CW) - 1) m_cnt[d][m_sel[d]]++;
      m_ptr[d] = (m_sel[d] + 1) % 4;
      if (iv) begin
        m_data[d] = id; m_sel[d] = (m_sel[d] + 1) % 4; m_age[d] = 0;
      end else begin
        m_full[d] = 0;
      end
    end else if (tmo_cfg[d] > 0 && m_age[d] == tmo_cfg[d] - 1) begin
      m_sel[d] = (m_sel[d] + 1) % 4; m_age[d] = 0; m_bub[d] = 1; m_tmo[d] = 1;
    end else begin
      m_age[d]++;
    end
  endtask

  task automatic check_dut(input int d, input logic [3:0] ordy);
    string p;
    logic  exp_ir;
    p = (d == 0) ? "t0" : "t4";
    exp_ir = !m_full[d] || (!m_bub[d] && ordy[m_sel[d]]);
    check({p, ".out_valid"}, (d == 0) ? ov0 : ov4, exp_valid(d));
    check({p, ".in_ready"},  (d == 0) ? ir0 : ir4, exp_ir);
    check({p, ".out_data"},  (d == 0) ? od0 : od4, m_data[d]);
    check({p, ".sel"},       (d == 0) ? sl0 : sl4, m_sel[d]);
    check({p, ".timeout"},   (d == 0) ? to0 : to4, m_tmo[d]);
`ifdef DEMUX_SCHED_CNT_EN
    for (int k = 0; k < 4; k++)
      check($sformatf("%s.cnt%0d", p, k), (d == 0) ? cf0[k*CW +: CW] : cf4[k*CW +: CW], m_cnt[d][k]);
`endif
  endtask

  // One clock: drive inputs after the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle(input logic iv, input logic [7:0] id, input logic [3:0] ordy);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) check_dut(d, ordy);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, iv, id, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = '0;
    #1;
    check("rst.t0.out_valid", ov0, 4'b0000);
    check("rst.t4.out_valid", ov4, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset held 3 cycles, then idle checks of the reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 4'h0);
    cycle(1'b0, 8'h00, 4'h0);

    // Full-rate streaming to always-ready consumers
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 4'hF);
    repeat (2) cycle(1'b0, 8'h00, 4'hF);

    // Stalled channel 1: timeout re-targets B1 to channel 2 on the TIMEOUT=4 instance
    do_reset();
    cycle(1'b1, 8'hB0, 4'b1101);
    cycle(1'b1, 8'hB1, 4'b1101);
    repeat (8) cycle(1'b0, 8'h00, 4'b1101);
    cycle(1'b1, 8'hB2, 4'b1101);
    repeat (3) cycle(1'b0, 8'h00, 4'b1101);

    // No ready at all: C0 held, C1 waits until channel 0 becomes ready
    do_reset();
    cycle(1'b1, 8'hC0, 4'h0);
    repeat (6) cycle(1'b1, 8'hC1, 4'h0);
    cycle(1'b1, 8'hC1, 4'b0001);
    repeat (3) cycle(1'b0, 8'h00, 4'hF);

    // Asynchronous reset while a word is held on channel 2
    do_reset();
    cycle(1'b1, 8'hD0, 4'hF);
    cycle(1'b1, 8'hD1, 4'hF);
    cycle(1'b1, 8'hD2, 4'hF);
    cycle(1'b0, 8'h00, 4'h0);
    @(posedge clk);
    #2;
    check("async.before", ov0, 4'b0100);
    rst_n = 1'b0;
    #1;
    check("async.t0.out_valid", ov0, 4'b0000);
    check("async.t4.out_valid", ov4, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 8'hE0, 4'hF);
    cycle(1'b0, 8'h00, 4'hF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] r;
      r = 4'($urandom) | ((i % 64 < 32) ? 4'($urandom) : 4'h0);
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), r);
    end

    // Counter fill and saturation with always-ready consumers
    do_reset();
    for (int i = 0; i < 70; i++) cycle(1'b1, 8'(i), 4'hF);
    repeat (2) cycle(1'b0, 8'h00, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
